fetch_queue: RTL and testbench

- Instruction buffer between the instruction-memory response path and the decode stage; it is the producer of the fe1_* interface that decode consumes.
- Accepts fetched words tagged with PC, speculation id and fault status, and holds them in order in a small FIFO.
- Presents the head entry to decode and honours de_stall.
- Discards wrong-path words using the speculation-id scheme, and flushes on a PC redirect.

---
 rtl/fetch_queue.sv | 123 ++++++++++++
 tb/tb_fetch_queue.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/fetch_queue.sv
// In-order instruction buffer between the instruction-memory response path and decode.
// Wrong-path words are filtered by speculation id; a redirect or trap flushes everything.
module fetch_queue #(
    parameter int DEPTH = 2
) (
    input  logic        clk_core,
    input  logic        reset,
    input  logic        im_valid,
    input  logic [29:0] im_pc,
    input  logic [31:0] im_insn,
    input  logic        im_exc,
    input  logic        im_specid,
    output logic        fq_ready,
    output logic        fq_specid,
    input  logic        de_setpc,
    input  logic        de_setspecid,
    input  logic        csr_kill,
    output logic        fe1_valid,
    output logic        fe1_stall,
    output logic        fe1_exc,
    output logic [29:0] fe1_pc,
    output logic        fe1_specid,
    output logic [31:0] fe1_insn,
    input  logic        de_stall
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_COUNT = (AW + 1)'(DEPTH);

    typedef struct packed {
        logic [29:0] pc;
        logic [31:0] insn;
        logic        exc;
        logic        specid;
    } entry_t;

    entry_t        entries_q [DEPTH];
    logic [AW-1:0] rdPtr_q, rdPtr_d;
    logic [AW-1:0] wrPtr_q, wrPtr_d;
    logic [AW:0]   count_q, count_d;
    logic          curSpecid_q, curSpecid_d;
    logic          excHold_q, excHold_d;

    logic flush;
    logic toggle;
    logic doEnq;
    logic doDeq;
    entry_t head;

    assign flush  = de_setpc | csr_kill;
    assign toggle = (de_setpc & de_setspecid) | csr_kill;

    // A full queue never accepts, even when its head leaves this same cycle.
    assign fq_ready = (count_q != FULL_COUNT) & ~excHold_q & ~flush;
    assign doEnq    = im_valid & fq_ready & (im_specid == curSpecid_q);
    assign doDeq    = fe1_valid & ~de_stall & ~flush;

    assign head       = entries_q[rdPtr_q];
    assign fe1_valid  = (count_q != '0);
    assign fe1_stall  = (count_q == '0);
    assign fe1_exc    = head.exc;
    assign fe1_pc     = head.pc;
    assign fe1_specid = head.specid;
    assign fe1_insn   = head.insn;
    assign fq_specid  = curSpecid_q;

    always_comb begin
        rdPtr_d     = rdPtr_q;
        wrPtr_d     = wrPtr_q;
        count_d     = count_q;
        curSpecid_d = curSpecid_q;
        excHold_d   = excHold_q;

        if (flush) begin
            rdPtr_d   = '0;
            wrPtr_d   = '0;
            count_d   = '0;
            excHold_d = 1'b0;
            if (toggle) begin
                curSpecid_d = ~curSpecid_q;
            end
        end else begin
            if (doEnq) begin
                wrPtr_d = wrPtr_q + AW'(1);
                if (im_exc) begin
                    excHold_d = 1'b1;
                end
            end
            if (doDeq) begin
                rdPtr_d = rdPtr_q + AW'(1);
            end
            case ({doEnq, doDeq})
                2'b10:   count_d = count_q + (AW + 1)'(1);
                2'b01:   count_d = count_q - (AW + 1)'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk_core) begin
        if (reset) begin
            rdPtr_q     <= '0;
            wrPtr_q     <= '0;
            count_q     <= '0;
            curSpecid_q <= 1'b0;
            excHold_q   <= 1'b0;
        end else begin
            rdPtr_q     <= rdPtr_d;
            wrPtr_q     <= wrPtr_d;
            count_q     <= count_d;
            curSpecid_q <= curSpecid_d;
            excHold_q   <= excHold_d;
        end
    end

    // Payload storage carries no reset; validity is tracked by count alone.
    always_ff @(posedge clk_core) begin
        if (!reset && doEnq) begin
            entries_q[wrPtr_q] <= '{pc: im_pc, insn: im_insn, exc: im_exc, specid: im_specid};
        end
    end

endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue: directed steps followed by random traffic,
// every cycle compared against a queue-based behavioural model.
module tb_fetch_queue;

    localparam int DEPTH = 2;

    logic        clk_core = 1'b0;
    logic        reset = 1'b1;
    logic        im_valid = 1'b0;
    logic [29:0] im_pc = '0;
    logic [31:0] im_insn = '0;
    logic        im_exc = 1'b0;
    logic        im_specid = 1'b0;
    logic        fq_ready;
    logic        fq_specid;
    logic        de_setpc = 1'b0;
    logic        de_setspecid = 1'b0;
    logic        csr_kill = 1'b0;
    logic        fe1_valid;
    logic        fe1_stall;
    logic        fe1_exc;
    logic [29:0] fe1_pc;
    logic        fe1_specid;
    logic [31:0] fe1_insn;
    logic        de_stall = 1'b0;

    int total = 0;
    int bad = 0;

    typedef struct {
        logic [29:0] pc;
        logic [31:0] insn;
        logic        exc;
        logic        specid;
    } ent_t;

    ent_t mq[$];
    logic mSpec = 1'b0;
    logic mHold = 1'b0;

    fetch_queue #(.DEPTH(DEPTH)) dut (
        .clk_core(clk_core), .reset(reset),
        .im_valid(im_valid), .im_pc(im_pc), .im_insn(im_insn), .im_exc(im_exc),
        .im_specid(im_specid), .fq_ready(fq_ready), .fq_specid(fq_specid),
        .de_setpc(de_setpc), .de_setspecid(de_setspecid), .csr_kill(csr_kill),
        .fe1_valid(fe1_valid), .fe1_stall(fe1_stall), .fe1_exc(fe1_exc),
        .fe1_pc(fe1_pc), .fe1_specid(fe1_specid), .fe1_insn(fe1_insn),
        .de_stall(de_stall)
    );

    always #5 clk_core = ~clk_core;

    task automatic checkValue(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic modelReady();
        return (mq.size() != DEPTH) && !mHold && !(de_setpc || csr_kill);
    endfunction

    // Compares all visible outputs with the model state for the inputs now applied.
    task automatic checkOutput();
        checkValue("fe1_valid", 64'(fe1_valid), 64'(mq.size() != 0));
        checkValue("fe1_stall", 64'(fe1_stall), 64'(mq.size() == 0));
        checkValue("fq_ready", 64'(fq_ready), 64'(modelReady()));
        checkValue("fq_specid", 64'(fq_specid), 64'(mSpec));
        if (mq.size() != 0) begin
            checkValue("fe1_pc", 64'(fe1_pc), 64'(mq[0].pc));
            checkValue("fe1_insn", 64'(fe1_insn), 64'(mq[0].insn));
            checkValue("fe1_exc", 64'(fe1_exc), 64'(mq[0].exc));
            checkValue("fe1_specid", 64'(fe1_specid), 64'(mq[0].specid));
        end
    endtask

    task automatic modelStep();
        logic flushM, toggleM, enqM, deqM;
        flushM  = de_setpc || csr_kill;
        toggleM = (de_setpc && de_setspecid) || csr_kill;
        enqM    = im_valid && modelReady() && (im_specid == mSpec);
        deqM    = (mq.size() != 0) && !de_stall && !flushM;
        if (reset) begin
            mq.delete();
            mSpec = 1'b0;
            mHold = 1'b0;
        end else if (flushM) begin
            mq.delete();
            mHold = 1'b0;
            if (toggleM) mSpec = ~mSpec;
        end else begin
            if (deqM) void'(mq.pop_front());
            if (enqM) begin
                mq.push_back('{pc: im_pc, insn: im_insn, exc: im_exc, specid: im_specid});
                if (im_exc) mHold = 1'b1;
            end
        end
    endtask

    // Drives one cycle of inputs at the negedge, checks, then clocks the DUT and model.
    task automatic applyStimulus(input logic v, input logic [29:0] pc, input logic [31:0] insn,
                                 input logic exc, input logic sp, input logic setpc,
                                 input logic setsp, input logic kill, input logic stall,
                                 input logic rst);
        im_valid = v; im_pc = pc; im_insn = insn; im_exc = exc; im_specid = sp;
        de_setpc = setpc; de_setspecid = setsp; csr_kill = kill; de_stall = stall; reset = rst;
        #1;
        if (!rst) checkOutput();
        @(posedge clk_core);
        modelStep();
        @(negedge clk_core);
    endtask

    task automatic idle(input logic stall);
        applyStimulus(1'b0, '0, '0, 1'b0, mSpec, 1'b0, 1'b0, 1'b0, stall, 1'b0);
    endtask

    initial begin
        int accepted;
        int cyc;
        logic willTake;

        @(negedge clk_core);
        applyStimulus(1'b0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        applyStimulus(1'b0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        checkValue("rst_valid", 64'(fe1_valid), 64'(0));
        checkValue("rst_stall", 64'(fe1_stall), 64'(1));
        checkValue("rst_specid", 64'(fq_specid), 64'(0));

        // Single word passes through with one cycle of latency.
        applyStimulus(1'b1, 30'h40, 32'h00000013, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        checkValue("tp1_valid", 64'(fe1_valid), 64'(1));
        checkValue("tp1_pc", 64'(fe1_pc), 64'(30'h40));
        checkValue("tp1_insn", 64'(fe1_insn), 64'(32'h00000013));
        idle(1'b0);
        checkValue("tp1_empty", 64'(fe1_stall), 64'(1));

        // Fill while stalled; third word is dropped.
        applyStimulus(1'b1, 30'h40, 32'hA0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        applyStimulus(1'b1, 30'h41, 32'hA1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        applyStimulus(1'b1, 30'h42, 32'hA2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        checkValue("tp2_full", 64'(fq_ready), 64'(0));
        idle(1'b0);
        checkValue("tp2_second", 64'(fe1_pc), 64'(30'h41));
        idle(1'b0);
        idle(1'b0);

        // Redirect with id toggle, then stale and fresh words.
        applyStimulus(1'b1, 30'h50, 32'hB0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        applyStimulus(1'b1, 30'h51, 32'hB1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        applyStimulus(1'b0, '0, '0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        checkValue("tp3_specid", 64'(fq_specid), 64'(1));
        applyStimulus(1'b1, 30'h60, 32'hC0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 30'h61, 32'hC1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        checkValue("tp3_fresh", 64'(fe1_pc), 64'(30'h61));
        idle(1'b0);

        // Redirect without toggle swallows a concurrent word.
        applyStimulus(1'b1, 30'h70, 32'hD0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        checkValue("tp4_empty", 64'(fe1_valid), 64'(0));
        idle(1'b0);

        // Faulting word blocks later words until a trap flush.
        applyStimulus(1'b1, 30'h80, 32'hE0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 30'h81, 32'hE1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 30'h82, 32'hE2, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        checkValue("tp5_drained", 64'(fe1_valid), 64'(0));
        idle(1'b0);
        applyStimulus(1'b0, '0, '0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        checkValue("tp5_specid", 64'(fq_specid), 64'(0));
        idle(1'b0);

        // Ten words streamed across pointer wrap with de_stall toggling every 3 cycles.
        accepted = 0;
        cyc = 0;
        while (accepted < 10 && cyc < 60) begin
            willTake = modelReady();
            applyStimulus(1'b1, 30'h100 + 30'(accepted), 32'h1000 + 32'(accepted), 1'b0, mSpec,
                          1'b0, 1'b0, 1'b0, logic'((cyc / 3) % 2), 1'b0);
            if (willTake) accepted++;
            cyc++;
        end
        checkValue("tp6_accepted", 64'(accepted), 64'(10));
        applyStimulus(1'b0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        checkValue("tp6_rst_valid", 64'(fe1_valid), 64'(0));
        checkValue("tp6_rst_spec", 64'(fq_specid), 64'(0));
        checkValue("tp6_rst_ready", 64'(fq_ready), 64'(1));

        // Random traffic against the model.
        for (int i = 0; i < 400; i++) begin
            logic sp;
            sp = ($urandom_range(0, 9) < 8) ? mSpec : ~mSpec;
            applyStimulus(logic'($urandom_range(0, 9) < 7), 30'($urandom), $urandom,
                          logic'($urandom_range(0, 19) == 0), sp,
                          logic'($urandom_range(0, 19) == 0), logic'($urandom_range(0, 1)),
                          logic'($urandom_range(0, 29) == 0), logic'($urandom_range(0, 9) < 4),
                          logic'($urandom_range(0, 99) == 0));
        end
        idle(1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
